// File: rtl/clock_mux_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clock_mux_ctrl_pkg
// Description : Shared types and constants for the clock mux select
//               sequencer (state encoding, counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package clock_mux_ctrl_pkg;

    // Width of the gate/settle down-counter
    localparam int c_CNT_W = 8;

    // Sequencer state encoding
    typedef logic [1:0] state_t;

    localparam state_t c_ST_INIT   = 2'd0;
    localparam state_t c_ST_IDLE   = 2'd1;
    localparam state_t c_ST_GATE   = 2'd2;
    localparam state_t c_ST_SETTLE = 2'd3;

endpackage : clock_mux_ctrl_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : 1-bit two-flop synchronizer with a parameterised reset value.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; both reset to RST_VAL so reset release is quiet
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/clock_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_mux_sel_ctrl
// Description : Glitch-free select sequencer for a downstream clock mux.
//               Gates the muxed clock, waits GATE_CYC cycles, flips the
//               select, waits SETTLE_CYC cycles, then re-enables the clock.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_mux_sel_ctrl
    import clock_mux_ctrl_pkg::*;
#(
    parameter int   GATE_CYC   = 4,
    parameter int   SETTLE_CYC = 3,
    parameter logic RST_SEL    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_sel,
    output logic mux_sel,
    output logic clk_en,
    output logic busy,
    output logic done
);

    // Counter reload values; loads never exceed 254 so the counter cannot wrap
    localparam logic [c_CNT_W-1:0] c_GATE_LD   = c_CNT_W'(GATE_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE_LD = c_CNT_W'(SETTLE_CYC - 1);

    logic               w_req_sync;
    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_mux_sel;
    logic               r_clk_en;
    logic               r_busy;
    logic               r_done;
    logic               w_cnt_zero;

    sync_2ff #(
        .RST_VAL (RST_SEL)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .i_d (req_sel),
        .o_q (w_req_sync)
    );

    assign w_cnt_zero = (r_cnt == '0);

    // Sequencer FSM with its down-counter and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_INIT;
            r_cnt     <= c_SETTLE_LD;
            r_mux_sel <= RST_SEL;
            r_clk_en  <= 1'b0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_ST_INIT: begin
                    // Post-reset settle: no done pulse on completion
                    if (w_cnt_zero) begin
                        r_state  <= c_ST_IDLE;
                        r_clk_en <= 1'b1;
                        r_busy   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_IDLE: begin
                    if (w_req_sync != r_mux_sel) begin
                        r_state  <= c_ST_GATE;
                        r_clk_en <= 1'b0;
                        r_busy   <= 1'b1;
                        r_cnt    <= c_GATE_LD;
                    end
                end
                c_ST_GATE: begin
                    // Select flips only here, with the clock already gated
                    if (w_cnt_zero) begin
                        r_mux_sel <= ~r_mux_sel;
                        r_state   <= c_ST_SETTLE;
                        r_cnt     <= c_SETTLE_LD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_ST_SETTLE: begin
                    if (w_cnt_zero) begin
                        r_state  <= c_ST_IDLE;
                        r_clk_en <= 1'b1;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= c_ST_INIT;
                    r_cnt    <= c_SETTLE_LD;
                    r_clk_en <= 1'b0;
                    r_busy   <= 1'b1;
                end
            endcase
        end
    end

    assign mux_sel = r_mux_sel;
    assign clk_en  = r_clk_en;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule : clock_mux_sel_ctrl
`default_nettype wire

// File: tb/tb_clock_mux_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_mux_sel_ctrl
// Description : Directed self-checking bench for clock_mux_sel_ctrl
//               (GATE_CYC=4, SETTLE_CYC=3, RST_SEL=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_mux_sel_ctrl;

    logic clk;
    logic rst;
    logic req_sel;
    logic mux_sel;
    logic clk_en;
    logic busy;
    logic done;

    int n_checks = 0;
    int n_pass   = 0;

    // Per-edge history: index e holds outputs just after edge (k + e)
    logic ce_h [0:31];
    logic ms_h [0:31];
    logic bz_h [0:31];
    logic dn_h [0:31];

    // Glitch monitor state
    logic mon_en   = 1'b0;
    logic prev_vld = 1'b0;
    logic prev_ms;
    logic prev_ce;
    int   n_viol   = 0;
    int   low_run  = 0;
    int   min_low  = 1000;
    int   n_low    = 0;

    clock_mux_sel_ctrl #(
        .GATE_CYC   (4),
        .SETTLE_CYC (3),
        .RST_SEL    (1'b0)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .req_sel (req_sel),
        .mux_sel (mux_sel),
        .clk_en  (clk_en),
        .busy    (busy),
        .done    (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance n edges, logging outputs at history slots base..base+n-1
    task automatic record(input int base, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            ce_h[base+i] = clk_en;
            ms_h[base+i] = mux_sel;
            bz_h[base+i] = busy;
            dn_h[base+i] = done;
        end
    endtask

    function automatic int count_busy(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(bz_h[i]);
        return c;
    endfunction

    function automatic int count_done(input int n);
        int c = 0;
        for (int i = 0; i < n; i++) c += int'(dn_h[i]);
        return c;
    endfunction

    // Glitch monitor: select must never move while the clock is enabled,
    // and every gated window must be at least GATE_CYC+SETTLE_CYC long
    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_vld) begin
                assert (!((mux_sel != prev_ms) && (clk_en || prev_ce)))
                    else $error("FAIL glitch: mux_sel changed while clk_en=1");
                if ((mux_sel != prev_ms) && (clk_en || prev_ce)) n_viol++;
            end
            if (!clk_en) begin
                low_run++;
            end else if (low_run > 0) begin
                if (low_run < min_low) min_low = low_run;
                n_low++;
                low_run = 0;
            end
            prev_ms  = mux_sel;
            prev_ce  = clk_en;
            prev_vld = 1'b1;
        end
    end

    initial begin
        rst     = 1'b1;
        req_sel = 1'b0;

        // ---- Reset state ----
        repeat (3) tick();
        check("rst_mux_sel", mux_sel, 0);
        check("rst_clk_en",  clk_en,  0);
        check("rst_busy",    busy,    1);
        check("rst_done",    done,    0);

        // ---- Reset release: slot 0 is edge r ----
        rst = 1'b0;
        record(0, 6);
        check("init_ce_r1",   ce_h[1], 0);
        check("init_busy_r1", bz_h[1], 1);
        check("init_ce_r2",   ce_h[2], 1);
        check("init_busy_r2", bz_h[2], 0);
        check("init_mux_sel", ms_h[5], 0);
        check("init_no_done", count_done(6), 0);

        // ---- Switch 0->1: slot 0 is edge k ----
        req_sel = 1'b1;
        record(0, 12);
        check("sw_ce_k1",    ce_h[1], 1);
        check("sw_ce_k2",    ce_h[2], 0);
        check("sw_busy_k2",  bz_h[2], 1);
        check("sw_ms_k5",    ms_h[5], 0);
        check("sw_ms_k6",    ms_h[6], 1);
        check("sw_ce_k8",    ce_h[8], 0);
        check("sw_ce_k9",    ce_h[9], 1);
        check("sw_done_k9",  dn_h[9], 1);
        check("sw_done_k10", dn_h[10], 0);
        check("sw_busy_len", count_busy(12), 7);
        check("sw_done_cnt", count_done(12), 1);

        // ---- Plain switch back 1->0 ----
        req_sel = 1'b0;
        record(0, 12);
        check("back_ms", ms_h[11], 0);
        check("back_ce", ce_h[11], 1);

        // ---- Mid-sequence reversal: 1 sampled at k, 0 sampled at k+4 ----
        req_sel = 1'b1;
        record(0, 4);
        req_sel = 1'b0;
        record(4, 16);
        check("rev_ms_k9",    ms_h[9],  1);
        check("rev_ce_k9",    ce_h[9],  1);
        check("rev_done_k9",  dn_h[9],  1);
        check("rev_ce_k10",   ce_h[10], 0);
        check("rev_ms_k13",   ms_h[13], 1);
        check("rev_ms_k14",   ms_h[14], 0);
        check("rev_ce_k16",   ce_h[16], 0);
        check("rev_ce_k17",   ce_h[17], 1);
        check("rev_done_k17", dn_h[17], 1);
        check("rev_done_cnt", count_done(20), 2);

        // ---- Reset mid-switch (asserted after edge k+5) ----
        req_sel = 1'b1;
        record(0, 6);
        check("mid_ce_k5", ce_h[5], 0);
        rst     = 1'b1;
        req_sel = 1'b0;
        tick();
        check("mid_rst_mux_sel", mux_sel, 0);
        check("mid_rst_clk_en",  clk_en,  0);
        check("mid_rst_busy",    busy,    1);
        tick();
        rst = 1'b0;
        record(0, 6);
        check("reinit_ce_r1",   ce_h[1], 0);
        check("reinit_busy_r1", bz_h[1], 1);
        check("reinit_ce_r2",   ce_h[2], 1);
        check("reinit_busy_r2", bz_h[2], 0);
        check("reinit_ms",      ms_h[5], 0);
        check("reinit_no_done", count_done(6), 0);

        // ---- Pulse between edges is never sampled ----
        req_sel = 1'b1;
        #3;
        req_sel = 1'b0;
        record(0, 12);
        check("pulse_busy", count_busy(12), 0);
        check("pulse_ms",   ms_h[11], 0);

        // ---- Random toggling with glitch monitor ----
        mon_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            tick();
            if ($urandom_range(0, 15) == 0) req_sel = ~req_sel;
        end
        repeat (30) tick();
        mon_en = 1'b0;
        check("rand_busy_end", busy, 0);
        check("rand_ms_end",   mux_sel, req_sel);
        check("rand_viol",     n_viol, 0);
        check("rand_min_low",  (min_low >= 7), 1);
        check("rand_seq_seen", (n_low > 10), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_clock_mux_sel_ctrl
`default_nettype wire
